// File: rtl/disp_scan_pwm.sv
// disp_scan_pwm: multiplexed common-anode 7-segment driver with frame snapshot, PWM dimming and dead time
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-low
//   hexs       in   4*DIGITS hex values, [3:0] = digit 0 (rightmost)
//   points     in   DIGITS decimal points, 1 = lit
//   les        in   DIGITS digit enables, 0 = shown, 1 = blanked
//   brightness in   BRIGHT_W duty level, 0 = dimmest
//   an         out  DIGITS anodes, active-low
//   segment    out  8 active-low segments {p,g,f,e,d,c,b,a}
//   frame_done out  one-cycle pulse after the last slot of a frame
//
// Optional feature: define DISP_LZ_BLANK_EN for leading-zero suppression.
module disp_scan_pwm #(
    parameter int DIGITS      = 4,
    parameter int DIV_W       = 17,
    parameter int BRIGHT_W    = 4,
    parameter int DEAD_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   hexs,
    input  logic [DIGITS-1:0]     points,
    input  logic [DIGITS-1:0]     les,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            segment,
    output logic                  frame_done
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    localparam logic [DIV_W-1:0] DEAD = DIV_W'(DEAD_CYCLES);

    logic [DIV_W-1:0]    cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] hex_sh;
    logic [DIGITS-1:0]   pt_sh;
    logic [DIGITS-1:0]   le_sh;
    logic [BRIGHT_W-1:0] br_sh;
    logic [DIGITS-1:0]   lz;
    logic [3:0]          digit;
    logic [6:0]          glyph;
    logic                lit;

`ifdef DISP_LZ_BLANK_EN
    // lz[k] is set when digit k and every digit above it are zero with no point;
    // digit 0 always stays visible
    for (genvar k = 0; k < DIGITS; k++) begin : g_lz
        if (k == 0) begin : g_first
            assign lz[k] = 1'b0;
        end else if (k == DIGITS - 1) begin : g_top
            assign lz[k] = hex_sh[4*k +: 4] == 4'h0 && !pt_sh[k];
        end else begin : g_mid
            assign lz[k] = hex_sh[4*k +: 4] == 4'h0 && !pt_sh[k] && lz[k+1];
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        digit = hex_sh[4*idx +: 4];
        case (digit)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
        // dead time blanks the slot start; the top counter bits form the PWM ramp
        lit = cnt >= DEAD && cnt[DIV_W-1 -: BRIGHT_W] <= br_sh && !le_sh[idx] && !lz[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            idx        <= '0;
            hex_sh     <= '0;
            pt_sh      <= '0;
            le_sh      <= '1;
            br_sh      <= '0;
            an         <= '1;
            segment    <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (&cnt)
                idx <= idx == LAST ? '0 : idx + 1'b1;
            // snapshot once per frame so mid-frame input changes never tear
            if (cnt == '0 && idx == '0) begin
                hex_sh <= hexs;
                pt_sh  <= points;
                le_sh  <= les;
                br_sh  <= brightness;
            end
            an         <= lit ? ~(DIGITS'(1) << idx) : '1;
            segment    <= lit ? {~pt_sh[idx], glyph} : 8'hFF;
            frame_done <= &cnt && idx == LAST;
        end
    end
endmodule

// File: tb/tb_disp_scan_pwm.sv
// tb_disp_scan_pwm: randomized self-checking bench for disp_scan_pwm against a slot/cycle arithmetic model
module tb_disp_scan_pwm;
    localparam int D     = 4;
    localparam int DW    = 4;
    localparam int BW    = 2;
    localparam int DC    = 2;
    localparam int SLOT  = 1 << DW;
    localparam int FRAME = SLOT * D;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] hexs = '0;
    logic [3:0]  points = '0;
    logic [3:0]  les = '0;
    logic [1:0]  brightness = '0;
    logic [3:0]  an;
    logic [7:0]  segment;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int p = 0;

    logic [15:0] m_hex;
    logic [3:0]  m_pt, m_les;
    logic [1:0]  m_br;
    logic        e_fd;
    logic [3:0]  e_an;
    logic [7:0]  e_seg;
    logic [6:0]  dec_t [16];

    disp_scan_pwm #(.DIGITS(D), .DIV_W(DW), .BRIGHT_W(BW), .DEAD_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .hexs(hexs), .points(points), .les(les),
        .brightness(brightness), .an(an), .segment(segment), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Advance one clock and compute what the outputs must show for frame position p.
    task automatic tick;
        int slot, c;
        logic lit, lzb;
        if (k % FRAME == 0) begin
            m_hex = hexs; m_pt = points; m_les = les; m_br = brightness;
        end
        @(posedge clk);
        #1;
        p = k % FRAME;
        slot = p / SLOT;
        c = p % SLOT;
        lzb = 1'b0;
`ifdef DISP_LZ_BLANK_EN
        if (slot > 0) begin
            lzb = 1'b1;
            for (int j = slot; j < D; j++)
                if (m_hex[4*j +: 4] != 4'h0 || m_pt[j]) lzb = 1'b0;
        end
`endif
        lit = c >= DC && (c / (SLOT >> BW)) <= int'(m_br) && !m_les[slot] && !lzb;
        e_an = lit ? ~(4'b0001 << slot) : 4'hF;
        e_seg = lit ? {~m_pt[slot], dec_t[m_hex[4*slot +: 4]]} : 8'hFF;
        e_fd = p == FRAME - 1;
        k++;
    endtask

    task automatic sync_frame;
        while (k % FRAME != 0) tick();
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hexs = 16'($urandom); points = 4'($urandom); les = 4'($urandom); brightness = 2'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({frame_done, an, segment} !== {1'b0, 4'hF, 8'hFF}) begin
                errors++;
                $display("FAIL reset cyc=%0d got fd=%b an=%h seg=%h exp 0 f ff", i, frame_done, an, segment);
            end
        end
        rst = 1'b1;
        k = 0;
    endtask

    task automatic test_basic;
        sync_frame();
        hexs = 16'h1234; points = 4'h0; les = 4'h0; brightness = 2'd3;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            checks++;
            if ({frame_done, an, segment} !== {e_fd, e_an, e_seg}) begin
                errors++;
                $display("FAIL basic p=%0d got %b %h %h exp %b %h %h", p, frame_done, an, segment, e_fd, e_an, e_seg);
            end
            if (p == 2 || p == 15 || p == 50) begin
                checks++;
                if ({an, segment} !== (p == 50 ? {4'b0111, 8'hF9} : {4'b1110, 8'h99})) begin
                    errors++;
                    $display("FAIL basic_const p=%0d got an=%b seg=%h", p, an, segment);
                end
            end
            if (p == 1) begin
                checks++;
                if ({an, segment} !== {4'hF, 8'hFF}) begin
                    errors++;
                    $display("FAIL basic_dead got an=%b seg=%h exp 1111 ff", an, segment);
                end
            end
        end
    endtask

    task automatic test_brightness;
        for (int b = 0; b < 4; b++) begin
            int on = 0;
            sync_frame();
            hexs = 16'($urandom) | 16'h1111; points = 4'($urandom); les = 4'h0; brightness = 2'(b);
            for (int i = 0; i < FRAME; i++) begin
                tick();
                if (p < SLOT && an[0] === 1'b0) on++;
                checks++;
                if ({frame_done, an, segment} !== {e_fd, e_an, e_seg}) begin
                    errors++;
                    $display("FAIL bright b=%0d p=%0d got %b %h %h exp %b %h %h", b, p, frame_done, an, segment, e_fd, e_an, e_seg);
                end
            end
            checks++;
            if (on != 4 * (b + 1) - 2) begin
                errors++;
                $display("FAIL bright_duty b=%0d got %0d exp %0d", b, on, 4 * (b + 1) - 2);
            end
        end
    endtask

    task automatic test_snapshot;
        int pulses = 0;
        sync_frame();
        hexs = 16'h1234; points = 4'h0; les = 4'h0; brightness = 2'd3;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 20) hexs = 16'hABCD;
            tick();
            if (frame_done === 1'b1) pulses++;
            checks++;
            if ({frame_done, an, segment} !== {e_fd, e_an, e_seg}) begin
                errors++;
                $display("FAIL snap i=%0d got %b %h %h exp %b %h %h", i, frame_done, an, segment, e_fd, e_an, e_seg);
            end
            if (i == 50 || i == 66 || i == 114) begin
                checks++;
                if (segment !== (i == 50 ? 8'hF9 : i == 66 ? 8'hA1 : 8'h88)) begin
                    errors++;
                    $display("FAIL snap_digit i=%0d got seg=%h", i, segment);
                end
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL snap_frame_done got %0d pulses exp 2", pulses);
        end
    endtask

    task automatic test_les_points;
        sync_frame();
        hexs = 16'($urandom); points = 4'b0100; les = 4'b0010; brightness = 2'd3;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            checks++;
            if ({frame_done, an, segment} !== {e_fd, e_an, e_seg}) begin
                errors++;
                $display("FAIL les p=%0d got %b %h %h exp %b %h %h", p, frame_done, an, segment, e_fd, e_an, e_seg);
            end
            if (p / SLOT == 1) begin
                checks++;
                if (an !== 4'hF) begin
                    errors++;
                    $display("FAIL les_blank p=%0d got an=%b exp 1111", p, an);
                end
            end
            if (p == 2 * SLOT + 5) begin
                checks++;
                if ({an, segment[7]} !== {4'b1011, 1'b0}) begin
                    errors++;
                    $display("FAIL les_point got an=%b p=%b exp 1011 0", an, segment[7]);
                end
            end
        end
    endtask

    task automatic test_lz;
        sync_frame();
        hexs = 16'h0050; points = 4'h0; les = 4'h0; brightness = 2'd3;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            checks++;
            if ({frame_done, an, segment} !== {e_fd, e_an, e_seg}) begin
                errors++;
                $display("FAIL lz p=%0d got %b %h %h exp %b %h %h", p, frame_done, an, segment, e_fd, e_an, e_seg);
            end
            if (p == 5 || p == 21) begin
                checks++;
                if (segment !== (p == 5 ? 8'hC0 : 8'h92)) begin
                    errors++;
                    $display("FAIL lz_digit p=%0d got seg=%h", p, segment);
                end
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 6 * FRAME; i++) begin
            if ($urandom_range(7) == 0) begin
                hexs = 16'($urandom); points = 4'($urandom); les = 4'($urandom); brightness = 2'($urandom);
            end
            tick();
            checks++;
            if ({frame_done, an, segment} !== {e_fd, e_an, e_seg}) begin
                errors++;
                $display("FAIL rand k=%0d got %b %h %h exp %b %h %h", k, frame_done, an, segment, e_fd, e_an, e_seg);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n = int'($urandom_range(60, 20));
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({frame_done, an, segment} !== {1'b0, 4'hF, 8'hFF}) begin
            errors++;
            $display("FAIL reset_mid got fd=%b an=%h seg=%h exp 0 f ff", frame_done, an, segment);
        end
        rst = 1'b1;
        k = 0;
        hexs = 16'($urandom); points = 4'($urandom); les = 4'($urandom); brightness = 2'($urandom);
        for (int i = 0; i < FRAME + 4; i++) begin
            tick();
            checks++;
            if ({frame_done, an, segment} !== {e_fd, e_an, e_seg}) begin
                errors++;
                $display("FAIL reset_mid_run k=%0d got %b %h %h exp %b %h %h", k, frame_done, an, segment, e_fd, e_an, e_seg);
            end
        end
    endtask

    initial begin
        dec_t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        test_reset();
        test_basic();
        test_brightness();
        test_snapshot();
        test_les_points();
        test_lz();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
